// File: rtl/seq_det_pkg.sv
// Shared types and parameter limits for the serial pattern detector.
package seq_det_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StHunt
   } state_e;

   localparam int unsigned PatWMin = 2;
   localparam int unsigned PatWMax = 32;

   function automatic bit pat_w_legal(int unsigned w);
      return (w >= PatWMin) && (w <= PatWMax);
   endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module seq_det_match_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial detector for a run-time loadable PAT_W-bit pattern, MSB received first.
// Define MATCH_COUNT_EN to add the saturating match_cnt_o output.
module param_seq_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             din_valid_i,
   input  logic             din_i,
   input  logic             pat_load_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic             overlap_i,
   output logic             match_o,
`ifdef MATCH_COUNT_EN
   output logic [CNT_W-1:0] match_cnt_o,
`endif
   output logic             armed_o
);

   if (!pat_w_legal(PAT_W)) begin : gen_bad_pat_w
      $error("param_seq_detector: PAT_W out of range");
   end
   if (CNT_W == 0) begin : gen_bad_cnt_w
      $error("param_seq_detector: CNT_W must be non-zero");
   end

   localparam int unsigned    FillW    = $clog2(PAT_W + 1);
   localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [PAT_W-1:0]   hist_q, hist_d;
   logic [FillW-1:0]   fill_q, fill_d;
   logic               match_q, match_d;

   logic               accept;
   logic [PAT_W-1:0]   hist_shift;
   logic [FillW-1:0]   fill_inc;
   logic               full;
   logic               hit;

   // A load discards any coincident beat, so it can never complete a match.
   always_comb begin
      accept     = din_valid_i && !pat_load_i && (state_q != StIdle);
      hist_shift = {hist_q[PAT_W-2:0], din_i};
      fill_inc   = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);
      full       = (fill_inc == FillFull);
      hit        = accept && full && (hist_shift == pat_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (pat_load_i) state_d = StFill;
         end
         StFill, StHunt: begin
            if (pat_load_i || (hit && !overlap_i)) begin
               state_d = StFill;
            end else if (accept && full) begin
               state_d = StHunt;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = hit;
      if (pat_load_i) begin
         pat_d  = pattern_i;
         hist_d = '0;
         fill_d = '0;
      end else if (accept) begin
         hist_d = hist_shift;
         // Non-overlapping mode demands PAT_W fresh bits after each match.
         fill_d = (hit && !overlap_i) ? '0 : fill_inc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pat_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
      end
   end

   always_comb begin
      match_o = match_q;
      armed_o = (state_q != StIdle);
   end

`ifdef MATCH_COUNT_EN
   seq_det_match_cnt #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (pat_load_i),
      .inc_i  (match_d),
      .cnt_o  (match_cnt_o)
   );
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Randomised and directed bench for param_seq_detector against a queue-based model.
// Exercises match_cnt_o only when MATCH_COUNT_EN is defined.
module tb_param_seq_detector;

   localparam int unsigned PAT_W  = 4;
   localparam int unsigned CNT_W  = 2;
   localparam int          CntMax = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             din_valid_i;
   logic             din_i;
   logic             pat_load_i;
   logic [PAT_W-1:0] pattern_i;
   logic             overlap_i;
   logic             match_o;
   logic             armed_o;
`ifdef MATCH_COUNT_EN
   logic [CNT_W-1:0] match_cnt_o;
`endif

   param_seq_detector #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .din_valid_i (din_valid_i),
      .din_i       (din_i),
      .pat_load_i  (pat_load_i),
      .pattern_i   (pattern_i),
      .overlap_i   (overlap_i),
      .match_o     (match_o),
`ifdef MATCH_COUNT_EN
      .match_cnt_o (match_cnt_o),
`endif
      .armed_o     (armed_o)
   );

   always #5 clk_i = ~clk_i;

   int tests  = 0;
   int fails  = 0;
   bit chk_en = 1'b0;

   // Model: bits accepted since the last clear, oldest first, at most PAT_W kept.
   int  win[$];
   int  m_pat;
   bit  m_armed;
   bit  exp_match;
   int  exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      win.delete();
      m_pat     = 0;
      m_armed   = 1'b0;
      exp_match = 1'b0;
      exp_cnt   = 0;
   endtask

   task automatic model_update(input int v, input int d, input int ld, input int p, input int ov);
      int val;
      exp_match = 1'b0;
      if (ld != 0) begin
         m_armed = 1'b1;
         m_pat   = p;
         win.delete();
         exp_cnt = 0;
         return;
      end
      if (!m_armed || v == 0) return;
      win.push_back(d);
      if (win.size() > PAT_W) void'(win.pop_front());
      if (win.size() == PAT_W) begin
         val = 0;
         foreach (win[i]) val = val * 2 + win[i];
         if (val == m_pat) begin
            exp_match = 1'b1;
            if (exp_cnt < CntMax) exp_cnt++;
            if (ov == 0) win.delete();
         end
      end
   endtask

   // Drive one beat at the falling edge; the model advances on the rising edge.
   task automatic step(input int v, input int d, input int ld, input int p, input int ov);
      @(negedge clk_i);
      din_valid_i = v[0];
      din_i       = d[0];
      pat_load_i  = ld[0];
      pattern_i   = PAT_W'(p);
      overlap_i   = ov[0];
      @(posedge clk_i);
      model_update(v, d, ld, p, ov);
   endtask

   task automatic feed(input logic [7:0] bits, input int n, input int ov);
      for (int i = n - 1; i >= 0; i--) step(1, int'(bits[i]), 0, 0, ov);
   endtask

   task automatic load(input int p, input int ov);
      step(0, 0, 1, p, ov);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_ni = 1'b0;
      model_reset();
      #1;
      check({tag, "_rst_match"}, 32'(match_o), 0);
      check({tag, "_rst_armed"}, 32'(armed_o), 0);
`ifdef MATCH_COUNT_EN
      check({tag, "_rst_cnt"}, 32'(match_cnt_o), 0);
`endif
      @(negedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("cyc_match", 32'(match_o), 32'(exp_match));
         check("cyc_armed", 32'(armed_o), 32'(m_armed));
`ifdef MATCH_COUNT_EN
         check("cyc_cnt", 32'(match_cnt_o), 32'(exp_cnt));
`endif
      end
   end

   initial begin
      din_valid_i = 1'b0;
      din_i       = 1'b0;
      pat_load_i  = 1'b0;
      pattern_i   = '0;
      overlap_i   = 1'b0;
      rst_ni      = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      #1;
      check("reset_match", 32'(match_o), 0);
      check("reset_armed", 32'(armed_o), 0);
`ifdef MATCH_COUNT_EN
      check("reset_cnt", 32'(match_cnt_o), 0);
`endif
      rst_ni = 1'b1;
      chk_en = 1'b1;

      // No pattern loaded: stream is ignored.
      feed(8'b1011, 4, 1);
      #1 check("noload_match", 32'(match_o), 0);
      check("noload_armed", 32'(armed_o), 0);

      // Basic match, one cycle after the fourth beat.
      load(4'b1011, 1);
      #1 check("load_armed", 32'(armed_o), 1);
      feed(8'b1011, 4, 1);
      #1 check("basic_match", 32'(match_o), 1);
`ifdef MATCH_COUNT_EN
      check("basic_cnt", 32'(match_cnt_o), 1);
`endif
      step(0, 0, 0, 0, 1);
      #1 check("basic_pulse_end", 32'(match_o), 0);

      // Overlapping: matches after beats 4 and 7.
      load(4'b1011, 1);
      feed(8'b1011, 4, 1);
      feed(8'b011, 3, 1);
      #1 check("ovl_second", 32'(match_o), 1);
`ifdef MATCH_COUNT_EN
      check("ovl_cnt", 32'(match_cnt_o), 2);
`endif

      // Non-overlapping: only after beat 4.
      load(4'b1011, 0);
      feed(8'b1011, 4, 0);
      #1 check("novl_first", 32'(match_o), 1);
      feed(8'b011, 3, 0);
      #1 check("novl_second", 32'(match_o), 0);

      // Gap beat ignored.
      load(4'b1011, 1);
      step(1, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      feed(8'b011, 3, 1);
      #1 check("gap_match", 32'(match_o), 1);

      // Load with valid mid-stream discards the beat and restarts.
      load(4'b1011, 1);
      feed(8'b10, 2, 1);
      step(1, 1, 1, 4'b1011, 1);
      feed(8'b101, 3, 1);
      #1 check("reload_partial", 32'(match_o), 0);
      feed(8'b1, 1, 1);
      #1 check("reload_match", 32'(match_o), 1);

      // Load coinciding with a completing beat yields no match.
      load(4'b1011, 1);
      feed(8'b101, 3, 1);
      step(1, 1, 1, 4'b1011, 1);
      #1 check("load_kills_match", 32'(match_o), 0);

      // Five overlapping matches saturate the counter, then async reset mid-pattern.
      load(4'b1011, 1);
      feed(8'b1011, 4, 1);
      for (int k = 0; k < 4; k++) feed(8'b011, 3, 1);
`ifdef MATCH_COUNT_EN
      #1 check("sat_cnt", 32'(match_cnt_o), 3);
`endif
      feed(8'b10, 2, 1);
      async_reset("mid");

      // Random traffic with occasional reloads and resets.
      load(int'($urandom_range(0, 15)), 1);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rnd");
         end else begin
            step(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0) ? 1 : 0);
         end
      end

      @(negedge clk_i);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
